// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply,
// restoring divide, MTHI/MTLO writes. Optional MADD/MADDU under `MDU_MADD_EN.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return {WIDTH{1'b0}} - x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return {(2*WIDTH){1'b0}} - x;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
`ifdef MDU_MADD_EN
    logic             madd_q, madd_d;
`endif

    logic             op_iter_s;
    logic             accept_s;
    logic             mt_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_sub_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_signed_s;

    // Decode which ops run through the iterative datapath.
    always_comb begin
        op_iter_s = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011: op_iter_s = 1'b1;
`ifdef MDU_MADD_EN
            3'b110, 3'b111:                 op_iter_s = 1'b1;
`endif
            default:                        op_iter_s = 1'b0;
        endcase
    end

    // Request qualification, operand magnitudes and per-step datapath terms.
    always_comb begin
        accept_s  = start && !busy_q && op_iter_s;
        mt_s      = start && !busy_q && (op[2:1] == 2'b10);
        a_neg_s   = op[0] & A[WIDTH-1];
        b_neg_s   = op[0] & B[WIDTH-1];
        mag_a_s   = a_neg_s ? neg_w(A) : A;
        mag_b_s   = b_neg_s ? neg_w(B) : B;
        sum_s     = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted_s = {work_hi_q, work_lo_q[WIDTH-1]};
        ge_s      = shifted_s >= {1'b0, opnd_q};
        // The remainder after a successful subtract is below the divisor, so W bits suffice.
        rem_sub_s = shifted_s[WIDTH-1:0] - opnd_q;
        prod_s    = {work_hi_q, work_lo_q};
        prod_signed_s = neg_res_q ? neg_2w(prod_s) : prod_s;
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        div_zero_d = 1'b0;
`ifdef MDU_MADD_EN
        madd_d     = madd_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_d   = S_CALC;
                    cnt_d     = {CNT_W{1'b0}};
                    is_div_d  = (op[2:1] == 2'b01);
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    dz_d      = (op[2:1] == 2'b01) && (B == {WIDTH{1'b0}});
                    work_hi_d = {WIDTH{1'b0}};
`ifdef MDU_MADD_EN
                    madd_d    = op[2];
`endif
                    if (op[2:1] == 2'b01) begin
                        work_lo_d = mag_a_s;
                        opnd_d    = mag_b_s;
                    end else begin
                        work_lo_d = mag_b_s;
                        opnd_d    = mag_a_s;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (mt_s) begin
                        if (op[0]) begin
                            lo_d = A;
                        end else begin
                            hi_d = A;
                        end
                    end else begin
                        hi_d = hi_q;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
                if (is_div_q) begin
                    // A zero divisor freezes the dividend so HI can return A unchanged.
                    if (dz_q) begin
                        work_lo_d = work_lo_q;
                    end else if (ge_s) begin
                        work_hi_d = rem_sub_s;
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi_d = shifted_s[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    work_hi_d = sum_s[WIDTH:1];
                    work_lo_d = {sum_s[0], work_lo_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                state_d    = S_DONE;
                div_zero_d = dz_q;
                if (is_div_q) begin
                    if (dz_q) begin
                        lo_d = {WIDTH{1'b1}};
                        hi_d = neg_rem_q ? neg_w(work_lo_q) : work_lo_q;
                    end else begin
                        lo_d = neg_res_q ? neg_w(work_lo_q) : work_lo_q;
                        hi_d = neg_rem_q ? neg_w(work_hi_q) : work_hi_q;
                    end
                end else begin
`ifdef MDU_MADD_EN
                    if (madd_q) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + prod_signed_s;
                    end else begin
                        {hi_d, lo_d} = prod_signed_s;
                    end
`else
                    {hi_d, lo_d} = prod_signed_s;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            work_hi_q  <= {WIDTH{1'b0}};
            work_lo_q  <= {WIDTH{1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MDU_MADD_EN
            madd_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef MDU_MADD_EN
            madd_q     <= madd_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32); MADD expectations follow MDU_MADD_EN.
module tb_mdu_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: presents one request for a single edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'b000; A = 32'h0; B = 32'h0;
    endtask

    // Waits (bounded) for done; reports cycles waited and number of busy samples seen.
    task automatic wait_done(output int cycles, output int busy_seen, output bit timed_out);
        cycles = 0; busy_seen = 0; timed_out = 1'b0;
        while (!done && cycles < 100) begin
            if (busy) busy_seen++;
            @(negedge clk);
            cycles++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, div_zero, HI, LO} !== {3'b000, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset: got b=%b d=%b z=%b HI=%h LO=%h want all zero", busy, done, div_zero, HI, LO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int c, bs; bit to;
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || c != 33) begin
            n_bad++; $display("FAIL multu_latency: got %0d cycles (timeout=%0b) want 33", c, to);
        end
        n_cmp++;
        if (bs != 33) begin
            n_bad++; $display("FAIL multu_busy: got %0d busy cycles want 33", bs);
        end
        n_cmp++;
        if ({HI, LO, div_zero} !== {32'hFFFFFFFE, 32'h00000001, 1'b0}) begin
            n_bad++; $display("FAIL multu_result: got HI=%h LO=%h z=%b want fffffffe 00000001 0", HI, LO, div_zero);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL multu_done_pulse: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_signed();
        int c, bs; bit to;
        issue(3'b001, 32'hFFFFFFFD, 32'd5);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO} !== {32'hFFFFFFFF, 32'hFFFFFFF1}) begin
            n_bad++; $display("FAIL mult_neg: got HI=%h LO=%h want ffffffff fffffff1", HI, LO);
        end
        @(negedge clk);
        issue(3'b011, 32'hFFFFFFF9, 32'd2);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO, div_zero} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin
            n_bad++; $display("FAIL div_neg: got HI=%h LO=%h z=%b want ffffffff fffffffd 0", HI, LO, div_zero);
        end
        @(negedge clk);
        issue(3'b011, 32'd7, 32'hFFFFFFFE);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO} !== {32'h00000001, 32'hFFFFFFFD}) begin
            n_bad++; $display("FAIL div_negdivisor: got HI=%h LO=%h want 00000001 fffffffd", HI, LO);
        end
        @(negedge clk);
    endtask

    task automatic test_div_edges();
        int c, bs; bit to;
        issue(3'b010, 32'd100, 32'd0);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO, div_zero} !== {32'h00000064, 32'hFFFFFFFF, 1'b1}) begin
            n_bad++; $display("FAIL divu_zero: got HI=%h LO=%h z=%b want 00000064 ffffffff 1", HI, LO, div_zero);
        end
        @(negedge clk);
        n_cmp++;
        if (div_zero !== 1'b0) begin
            n_bad++; $display("FAIL div_zero_clear: got %b want 0", div_zero);
        end
        issue(3'b011, 32'hFFFFFFF6, 32'd0);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO, div_zero} !== {32'hFFFFFFF6, 32'hFFFFFFFF, 1'b1}) begin
            n_bad++; $display("FAIL div_zero_signed: got HI=%h LO=%h z=%b want fffffff6 ffffffff 1", HI, LO, div_zero);
        end
        @(negedge clk);
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO, div_zero} !== {32'h00000000, 32'h80000000, 1'b0}) begin
            n_bad++; $display("FAIL div_min_m1: got HI=%h LO=%h z=%b want 00000000 80000000 0", HI, LO, div_zero);
        end
        @(negedge clk);
        issue(3'b010, 32'd1000, 32'd7);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO} !== {32'd6, 32'd142}) begin
            n_bad++; $display("FAIL divu_plain: got HI=%h LO=%h want 00000006 0000008e", HI, LO);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore_mt();
        int c, bs; bit to;
        issue(3'b000, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        issue(3'b010, 32'd9, 32'd3);
        start = 1'b1; op = 3'b100; A = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        wait_done(c, bs, to);
        n_cmp++;
        if (to || c != 27) begin
            n_bad++; $display("FAIL ignore_latency: got %0d cycles want 27", c);
        end
        n_cmp++;
        if ({HI, LO} !== {32'd0, 32'd12}) begin
            n_bad++; $display("FAIL ignore_result: got HI=%h LO=%h want 00000000 0000000c", HI, LO);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL ignore_no_rerun: got busy=%b done=%b want 0 0", busy, done);
        end
        issue(3'b100, 32'h1234, 32'h0);
        n_cmp++;
        if ({HI, LO, busy, done} !== {32'h1234, 32'd12, 2'b00}) begin
            n_bad++; $display("FAIL mthi: got HI=%h LO=%h b=%b d=%b want 00001234 0000000c 0 0", HI, LO, busy, done);
        end
        issue(3'b101, 32'h5678, 32'h0);
        n_cmp++;
        if ({HI, LO, busy, done} !== {32'h1234, 32'h5678, 2'b00}) begin
            n_bad++; $display("FAIL mtlo: got HI=%h LO=%h b=%b d=%b want 00001234 00005678 0 0", HI, LO, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int c, bs; bit to;
        issue(3'b000, 32'd6, 32'd7);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || LO !== 32'd42) begin
            n_bad++; $display("FAIL b2b_first: got LO=%h want 0000002a", LO);
        end
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(c, bs, to);
        n_cmp++;
        if (to || c != 33 || {HI, LO} !== {32'd0, 32'd1}) begin
            n_bad++; $display("FAIL b2b_second: got %0d cycles HI=%h LO=%h want 33 00000000 00000001", c, HI, LO);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        bit seen;
        issue(3'b011, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, HI, LO} !== {2'b00, 32'h0, 32'h0}) begin
            n_bad++; $display("FAIL reset_async: got b=%b d=%b HI=%h LO=%h want 0 0 0 0", busy, done, HI, LO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen || {HI, LO} !== {32'h0, 32'h0}) begin
            n_bad++; $display("FAIL reset_abandon: got activity=%b HI=%h LO=%h want 0 0 0", seen, HI, LO);
        end
    endtask

    task automatic test_madd();
        int c, bs; bit to;
        issue(3'b100, 32'h0, 32'h0);
        issue(3'b101, 32'hFFFFFFFF, 32'h0);
        issue(3'b110, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_done(c, bs, to);
        n_cmp++;
        if (to || c != 33 || {HI, LO} !== {32'd1, 32'd0}) begin
            n_bad++; $display("FAIL maddu: got %0d cycles HI=%h LO=%h want 33 00000001 00000000", c, HI, LO);
        end
        @(negedge clk);
        issue(3'b111, 32'hFFFFFFFF, 32'd2);
        wait_done(c, bs, to);
        n_cmp++;
        if (to || {HI, LO} !== {32'd0, 32'hFFFFFFFE}) begin
            n_bad++; $display("FAIL madd_signed: got HI=%h LO=%h want 00000000 fffffffe", HI, LO);
        end
`else
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL maddu_off_busy: got busy=%b want 0", busy);
        end
        wait_done(c, bs, to);
        n_cmp++;
        if (!to || bs != 0 || {HI, LO} !== {32'h0, 32'hFFFFFFFF}) begin
            n_bad++; $display("FAIL maddu_off: got done_seen=%b busy_cycles=%0d HI=%h LO=%h want 0 0 00000000 ffffffff", !to, bs, HI, LO);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'b000; A = 32'h0; B = 32'h0;
        #2;
        test_reset();
        test_multu();
        test_signed();
        test_div_edges();
        test_busy_ignore_mt();
        test_back_to_back();
        test_reset_midop();
        test_madd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
